// File: rtl/seg_pkg.sv
// Shared 7-segment definitions used by both the display driver and the
// pattern decoder so the two ends of the path agree on one code table.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns, bit6=a ... bit0=g, indexed by distance level
  localparam logic [6:0] SEG_CODE [0:7] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F
  };

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } seg_state_t;

  typedef struct packed {
    logic [2:0] level;
    logic       err;
  } seg_decode_t;

endpackage

// File: rtl/seg_pattern_decoder_if.sv
// Event channel from the segment pattern decoder to its consumer:
// valid/ready handshake plus sticky overrun reporting and its clear.
interface seg_pattern_decoder_if;

  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_level;
  logic       out_err;
  logic       overrun;
  logic       clr_overrun;

  modport master (
    output out_valid,
    output out_level,
    output out_err,
    output overrun,
    input  out_ready,
    input  clr_overrun
  );

  modport slave (
    input  out_valid,
    input  out_level,
    input  out_err,
    input  overrun,
    output out_ready,
    output clr_overrun
  );

endinterface

// File: rtl/seg_pattern_lut.sv
// Combinational reverse lookup: active-low segment pattern to level.
// Any pattern outside the code table reports err with level forced to 0.
module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0]  pattern,
  output seg_decode_t decode
);

  always_comb begin
    decode.level = 3'd0;
    decode.err   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pattern == SEG_CODE[i]) begin
        decode.level = 3'(i);
        decode.err   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Stability filter on the display segment bus; each newly settled pattern
// is decoded to a level and offered to a consumer through one holding register.
module seg_pattern_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic                  sample_en,
  seg_pattern_decoder_if.master evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]       cand;
  logic [6:0]       committed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  seg_state_t       state;
  seg_decode_t      hold;
  seg_decode_t      seg_decode;
  logic             valid_q;
  logic             overrun_q;
  logic             match;
  logic             lock_edge;
  logic             new_event;
  logic             accept;

  seg_pattern_lut u_lut (
    .pattern (seg_in),
    .decode  (seg_decode)
  );

  // A mismatch while LOCKED counts as a fresh lock edge too, which only
  // matters when STABLE_CYCLES=1 and the counter never leaves the maximum.
  always_comb begin
    match     = (seg_in == cand);
    cnt_next  = CNT_W'(1);
    if (match) begin
      cnt_next = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    end
    lock_edge = sample_en && (cnt_next == CNT_MAX) &&
                ((state == SETTLING) || !match);
    new_event = lock_edge && (seg_in != committed);
    accept    = valid_q && evt.out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand      <= SEG_BLANK;
      cnt       <= '0;
      committed <= SEG_BLANK;
      state     <= SETTLING;
    end else if (sample_en) begin
      cand  <= seg_in;
      cnt   <= cnt_next;
      state <= (cnt_next == CNT_MAX) ? LOCKED : SETTLING;
      if (new_event) begin
        committed <= seg_in;
      end
    end
  end

  // A new event always wins over acceptance, so out_valid stays high when both coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (new_event) begin
        hold    <= seg_decode;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end

      if (new_event && valid_q && !evt.out_ready) begin
        overrun_q <= 1'b1;
      end else if (evt.clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign evt.out_valid = valid_q;
  assign evt.out_level = hold.level;
  assign evt.out_err   = hold.err;
  assign evt.overrun   = overrun_q;

endmodule
